// File: rtl/pa_noc.sv
// Shared NoC definitions: port indices, one-hot port vectors and the XY routing rule.
package pa_noc;

  localparam int NOC_PACKET_WIDTH = 8;
  localparam int NUM_PORTS = 5;

  typedef enum logic [2:0] {
    NI    = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_e;

  typedef logic [NUM_PORTS-1:0] port_onehot_t;

  // Column first, then row; an all-zero result means the destination is outside the grid.
  function automatic port_onehot_t xy_route(input int dRow, input int dCol, input int row,
                                            input int col, input int gridRows,
                                            input int gridCols);
    port_onehot_t r;
    r = '0;
    if (dRow >= gridRows || dCol >= gridCols) r = '0;
    else if (dCol > col) r[EAST] = 1'b1;
    else if (dCol < col) r[WEST] = 1'b1;
    else if (dRow > row) r[SOUTH] = 1'b1;
    else if (dRow < row) r[NORTH] = 1'b1;
    else r[NI] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, which moves past the winner on each grant.
module noc_rr_arbiter #(
  parameter int NUM_REQ = 5
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptrNext;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Scanning from the farthest candidate back lets the nearest requester win.
  always_comb begin
    o_grant = '0;
    ptrNext = ptr;
    sum     = '0;
    idx     = '0;
    if (i_enable) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        sum = {1'b0, ptr} + (PTR_W+1)'(k);
        if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
        idx = sum[PTR_W-1:0];
        if (i_req[idx]) begin
          o_grant      = '0;
          o_grant[idx] = 1'b1;
          ptrNext      = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) ptr <= '0;
    else ptr <= ptrNext;
  end

endmodule

// File: rtl/synchronousFifo.sv
// Single-clock FIFO with show-ahead head output; pushes when full and pops when empty are ignored.
module synchronousFifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_push,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wrPtr;
  logic [ADDRESS_WIDTH-1:0] rdPtr;
  logic [ADDRESS_WIDTH:0]   count;
  logic                     pushEn;
  logic                     popEn;

  assign pushEn  = i_push && !o_full;
  assign popEn   = i_pop && !o_empty;
  assign o_empty = (count == '0);
  assign o_full  = (count == (ADDRESS_WIDTH+1)'(DEPTH));
  assign o_data  = mem[rdPtr];

  always_ff @(posedge i_clk) begin
    if (pushEn) mem[wrPtr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + ADDRESS_WIDTH'(1);
      if (popEn) rdPtr <= rdPtr + ADDRESS_WIDTH'(1);
      if (pushEn && !popEn) count <= count + (ADDRESS_WIDTH+1)'(1);
      else if (popEn && !pushEn) count <= count - (ADDRESS_WIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/noc_router_xbar.sv
// Five-port XY mesh router: buffered inputs, per-output round-robin crossbar, registered output slots.
module noc_router_xbar
  import pa_noc::*;
#(
  parameter int GRID_ROWS          = 4,
  parameter int GRID_COLS          = 4,
  parameter int PACKET_WIDTH       = pa_noc::NOC_PACKET_WIDTH,
  parameter int FIFO_ADDRESS_WIDTH = 2,
  parameter int ROW_LSB            = 2,
  parameter int COL_LSB            = 0,
  parameter int ROUTER_ROW         = 0,
  parameter int ROUTER_COL         = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_arst_n,
  input  logic [NUM_PORTS-1:0][PACKET_WIDTH-1:0] i_data,
  input  logic [NUM_PORTS-1:0]                 i_valid,
  output logic [NUM_PORTS-1:0]                 o_ready,
  output logic [NUM_PORTS-1:0][PACKET_WIDTH-1:0] o_data,
  output logic [NUM_PORTS-1:0]                 o_valid,
  input  logic [NUM_PORTS-1:0]                 i_ready,
  output logic                                 o_dropped
);
  localparam int ROW_W = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;

  logic [NUM_PORTS-1:0][PACKET_WIDTH-1:0] fifoHead;
  logic [NUM_PORTS-1:0] fifoEmpty;
  logic [NUM_PORTS-1:0] fifoFull;
  logic [NUM_PORTS-1:0] fifoPop;
  logic [NUM_PORTS-1:0] dropReq;
  logic [NUM_PORTS-1:0] slotFree;
  port_onehot_t         headRoute [NUM_PORTS];
  port_onehot_t         reqMatrix [NUM_PORTS];
  port_onehot_t         grant     [NUM_PORTS];
  logic                 droppedReg;

  genvar gi, gj;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : gInput
      logic [ROW_W-1:0] dRow;
      logic [COL_W-1:0] dCol;
      port_onehot_t     routeRaw;

      synchronousFifo #(
        .DATA_WIDTH   (PACKET_WIDTH),
        .ADDRESS_WIDTH(FIFO_ADDRESS_WIDTH)
      ) uFifo (
        .i_clk   (i_clk),
        .i_arst_n(i_arst_n),
        .i_data  (i_data[gi]),
        .i_push  (i_valid[gi] && !fifoFull[gi]),
        .i_pop   (fifoPop[gi]),
        .o_data  (fifoHead[gi]),
        .o_empty (fifoEmpty[gi]),
        .o_full  (fifoFull[gi])
      );

      assign o_ready[gi]   = !fifoFull[gi];
      assign dRow          = fifoHead[gi][ROW_LSB +: ROW_W];
      assign dCol          = fifoHead[gi][COL_LSB +: COL_W];
      assign routeRaw      = xy_route(int'(dRow), int'(dCol), ROUTER_ROW, ROUTER_COL,
                                      GRID_ROWS, GRID_COLS);
      assign headRoute[gi] = fifoEmpty[gi] ? '0 : routeRaw;
      // Out-of-grid heads bypass arbitration and are discarded immediately.
      assign dropReq[gi]   = !fifoEmpty[gi] && (routeRaw == '0);
    end

    for (gi = 0; gi < NUM_PORTS; gi++) begin : gTranspose
      for (gj = 0; gj < NUM_PORTS; gj++) begin : gReq
        assign reqMatrix[gi][gj] = headRoute[gj][gi];
      end
    end

    for (gi = 0; gi < NUM_PORTS; gi++) begin : gOutput
      logic                    slotValidReg;
      logic [PACKET_WIDTH-1:0] slotDataReg;
      logic [PACKET_WIDTH-1:0] grantData;

      assign slotFree[gi] = !slotValidReg || i_ready[gi];

      noc_rr_arbiter #(
        .NUM_REQ(NUM_PORTS)
      ) uArb (
        .i_clk   (i_clk),
        .i_arst_n(i_arst_n),
        .i_req   (reqMatrix[gi]),
        .i_enable(slotFree[gi]),
        .o_grant (grant[gi])
      );

      always_comb begin
        grantData = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (grant[gi][i]) grantData = grantData | fifoHead[i];
        end
      end

      // Data is cleared on a plain handshake so an idle slot always reads as zero.
      always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
          slotValidReg <= 1'b0;
          slotDataReg  <= '0;
        end else if (|grant[gi]) begin
          slotValidReg <= 1'b1;
          slotDataReg  <= grantData;
        end else if (i_ready[gi]) begin
          slotValidReg <= 1'b0;
          slotDataReg  <= '0;
        end
      end

      assign o_valid[gi] = slotValidReg;
      assign o_data[gi]  = slotDataReg;
    end
  endgenerate

  always_comb begin
    fifoPop = dropReq;
    for (int o = 0; o < NUM_PORTS; o++) fifoPop = fifoPop | grant[o];
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) droppedReg <= 1'b0;
    else droppedReg <= |dropReq;
  end

  assign o_dropped = droppedReg;

endmodule
